id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised decode stage for the 5-stage pipeline: decodes the instruction, reads the integrated register file and resolves branches in ID. It registers operands and control into an ID/EX pipeline register with stall and flush support, and detects RAW hazards to generate an IF/ID hold. Sits between the IF/ID register and the EX stage.

Parameters:
DATA_W, 32, register/operand/PC width (>=16)
NUM_REGS, 32, register file depth (2..32); rs/rt/rd indices >= NUM_REGS read 0, writes ignored
FWD_EN, 1, 1 = EX forwarding exists downstream (stall only on load-use); 0 = stall on any RAW vs EX or MEM

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  instr/pc_in hold a real instruction
pc_in  in  DATA_W  PC of instruction (byte address)
instr  in  32  [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
stall_in  in  1  downstream freeze
flush_in  in  1  squash instruction entering ID/EX
wb_en  in  1  register write enable
wb_dest  in  5  write index
wb_data  in  DATA_W  write data
mem_wb_en  in  1  MEM-stage instruction writes back
mem_dest  in  5  MEM-stage destination
hazard_stall  out  1  comb; hold PC and IF/ID
branch_taken  out  1  comb; redirect fetch
branch_target  out  DATA_W  comb; pc_in + 4 + (sext(imm)<<2)
ex_valid, ex_illegal  out  1 each  registered
ex_pc  out  DATA_W  registered PC
ex_cmd  out  4  ALU command
ex_mem_read, ex_mem_write, ex_wb_en  out  1 each  registered control
ex_val1, ex_val2  out  DATA_W  rs/rt register values
ex_opnd2  out  DATA_W  is_imm ? ext(imm) : rt value
ex_dest, ex_src1, ex_src2  out  5 each  dest/rs/rt indices for forwarding

Behaviour:
- Decode (op hex -> cmd, flags, dest): 00 NOP (no effect). 01 ADD cmd 0000 wb rd. 03 SUB 0010 wb rd. 05 AND 0100 wb rd. 06 OR 0101 wb rd. 20 ADDI 0000 sext imm wb rt. 21 ANDI 0100 zext imm wb rt. 24 LD 0000 sext mem_read wb rt. 25 ST 0000 sext mem_write. 28 BEZ taken if rs==0. 29 BNE taken if rs!=rt. 2A JMP always taken. Other op: NOP with ex_illegal=1.
- Sources used: rs by all except NOP/JMP/illegal; rt by ADD/SUB/AND/OR/ST/BNE.
- Register file: NUM_REGS x DATA_W, write on clk when wb_en. Reg 0 is constant 0; writes to 0 are ignored. Same-cycle write-through bypass: read index == wb_dest, wb_en=1, index != 0 returns wb_data. rst clears all registers.
- Hazard, a comb check on a used source index s != 0:
  - exm = ex_valid & ex_wb_en & ex_dest==s
  - memm = mem_wb_en & mem_dest==s
  - FWD_EN=1: stall if exm & ex_mem_read; branch ops also stall on any exm or memm.
  - FWD_EN=0: stall on exm or memm.
  - hazard_stall = id_valid & match & ~flush_in.
- branch_taken = id_valid & branch cond & ~hazard_stall & ~flush_in & ~stall_in.
- ID/EX register update priority, per clk edge:
  1. rst: all outputs 0, ex_valid=0.
  2. stall_in: hold all registered outputs.
  3. flush_in or hazard_stall or ~id_valid: bubble. ex_valid, ex_wb_en, ex_mem_read, ex_mem_write and ex_illegal go 0; data fields are don't-care and are driven 0.
  4. Otherwise, capture decode. ex_valid=1, latency 1 cycle.
- Branches/JMP/ST capture with ex_wb_en=0, and ex_dest=0 for these.
- Reset mid-stall: rst wins and clears state; hazard_stall is 0 the cycle after, since ex_valid=0.
- Simultaneous wb write and read of the same register: the new value appears on ex_val* the next cycle.

Test Plan:
- Reset check: rst for 2 cycles -> all ex_* = 0, ex_valid=0. Then ADD r1,r0,r0 (rd=1) -> ex_valid=1, ex_cmd=0000, ex_dest=1, ex_wb_en=1.
- Write-through: wb_en=1, wb_dest=3, wb_data=0x1234 in the same cycle as ADD r4,r3,r0 -> next cycle ex_val1=0x1234. A write to r0 -> ex_val1 stays 0.
- Load-use (FWD_EN=1): LD r5 then ADD r6,r5,r2 -> hazard_stall=1 for exactly one cycle and one bubble (ex_valid=0). ADD then issues. With a non-load producer: no stall.
- FWD_EN=0: ADDI r7 then SUB r8,r7,r7 -> stall for 2 cycles (EX match, then mem_wb_en/mem_dest=7 match), then issue.
- Branch: r2=0, BEZ r2 imm=0x0003 at pc 0x100 -> branch_taken=1, branch_target=0x110. With a pending EX write to r2: branch_taken=0 and stall.
- Control priority: stall_in=1 holds outputs unchanged. flush_in=1 -> bubble, branch_taken=0. Illegal op 0x3F -> ex_illegal=1, ex_wb_en=0, ex_valid=1.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage of the 5-stage pipeline.
// Decodes the IF/ID instruction, reads the integrated register file with
// write-through bypass, resolves branches in ID, detects RAW hazards against
// EX/MEM producers and registers operands/control into the ID/EX register.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [31:0]       instr,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_wb_en,
    input  logic [4:0]        mem_dest,
    output logic              hazard_stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              ex_valid,
    output logic              ex_illegal,
    output logic [DATA_W-1:0] ex_pc,
    output logic [3:0]        ex_cmd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_wb_en,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_opnd2,
    output logic [4:0]        ex_dest,
    output logic [4:0]        ex_src1,
    output logic [4:0]        ex_src2
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h03;
    localparam logic [5:0] OP_AND  = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h20;
    localparam logic [5:0] OP_ANDI = 6'h21;
    localparam logic [5:0] OP_LD   = 6'h24;
    localparam logic [5:0] OP_ST   = 6'h25;
    localparam logic [5:0] OP_BEZ  = 6'h28;
    localparam logic [5:0] OP_BNE  = 6'h29;
    localparam logic [5:0] OP_JMP  = 6'h2A;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign op  = instr[31:26];
    assign rs  = instr[25:21];
    assign rt  = instr[20:16];
    assign rd  = instr[15:11];
    assign imm = instr[15:0];

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              rs_ok, rt_ok, wb_ok;

    // Indices beyond the file depth read as zero and never get written.
    assign rs_ok = (rs != 5'd0) && (int'(rs) < NUM_REGS);
    assign rt_ok = (rt != 5'd0) && (int'(rt) < NUM_REGS);
    assign wb_ok = wb_en && (wb_dest != 5'd0) && (int'(wb_dest) < NUM_REGS);

    // Register reads with same-cycle write-through from the WB port.
    assign rs_val = !rs_ok ? '0 : (wb_en && wb_dest == rs) ? wb_data : regs[rs[AW-1:0]];
    assign rt_val = !rt_ok ? '0 : (wb_en && wb_dest == rt) ? wb_data : regs[rt[AW-1:0]];

    // Register file storage; reg 0 stays zero because writes to it are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[wb_dest[AW-1:0]] <= wb_data;
        end
    end

    logic [3:0]        d_cmd;
    logic              d_imm, d_sext, d_mr, d_mw, d_wb, d_ill;
    logic              use_rs, use_rt, d_br, br_cond;
    logic [4:0]        d_dest;
    logic [DATA_W-1:0] sext_imm, zext_imm, d_opnd2;

    assign sext_imm = {{(DATA_W-16){imm[15]}}, imm};
    assign zext_imm = {{(DATA_W-16){1'b0}}, imm};

    // Instruction decode: ALU command, memory/writeback flags, sources, branch condition.
    always_comb begin
        d_cmd   = 4'b0000;
        d_imm   = 1'b0;
        d_sext  = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_wb    = 1'b0;
        d_ill   = 1'b0;
        d_dest  = 5'd0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        d_br    = 1'b0;
        br_cond = 1'b0;
        case (op)
            OP_NOP:  begin end
            OP_ADD:  begin d_cmd = 4'b0000; d_wb = 1'b1; d_dest = rd; use_rs = 1'b1; use_rt = 1'b1; end
            OP_SUB:  begin d_cmd = 4'b0010; d_wb = 1'b1; d_dest = rd; use_rs = 1'b1; use_rt = 1'b1; end
            OP_AND:  begin d_cmd = 4'b0100; d_wb = 1'b1; d_dest = rd; use_rs = 1'b1; use_rt = 1'b1; end
            OP_OR:   begin d_cmd = 4'b0101; d_wb = 1'b1; d_dest = rd; use_rs = 1'b1; use_rt = 1'b1; end
            OP_ADDI: begin d_imm = 1'b1; d_sext = 1'b1; d_wb = 1'b1; d_dest = rt; use_rs = 1'b1; end
            OP_ANDI: begin d_cmd = 4'b0100; d_imm = 1'b1; d_wb = 1'b1; d_dest = rt; use_rs = 1'b1; end
            OP_LD:   begin d_imm = 1'b1; d_sext = 1'b1; d_mr = 1'b1; d_wb = 1'b1; d_dest = rt; use_rs = 1'b1; end
            OP_ST:   begin d_imm = 1'b1; d_sext = 1'b1; d_mw = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            OP_BEZ:  begin d_br = 1'b1; use_rs = 1'b1; br_cond = (rs_val == '0); end
            OP_BNE:  begin d_br = 1'b1; use_rs = 1'b1; use_rt = 1'b1; br_cond = (rs_val != rt_val); end
            OP_JMP:  begin d_br = 1'b1; br_cond = 1'b1; end
            default: d_ill = 1'b1;
        endcase
    end

    assign d_opnd2 = !d_imm ? rt_val : (d_sext ? sext_imm : zext_imm);

    logic exm_rs, exm_rt, memm_rs, memm_rt, hz_rs, hz_rt;

    assign exm_rs  = ex_valid && ex_wb_en && (ex_dest == rs);
    assign exm_rt  = ex_valid && ex_wb_en && (ex_dest == rt);
    assign memm_rs = mem_wb_en && (mem_dest == rs);
    assign memm_rt = mem_wb_en && (mem_dest == rt);

    // RAW check per used source. With forwarding only load-use stalls ALU ops,
    // but branches resolve here and must wait for any in-flight producer.
    always_comb begin
        if (FWD_EN != 0) begin
            hz_rs = (exm_rs && ex_mem_read) || (d_br && (exm_rs || memm_rs));
            hz_rt = (exm_rt && ex_mem_read) || (d_br && (exm_rt || memm_rt));
        end else begin
            hz_rs = exm_rs || memm_rs;
            hz_rt = exm_rt || memm_rt;
        end
    end

    assign hazard_stall = id_valid && !flush_in &&
                          ((use_rs && rs != 5'd0 && hz_rs) || (use_rt && rt != 5'd0 && hz_rt));
    assign branch_taken  = id_valid && br_cond && !hazard_stall && !flush_in && !stall_in;
    assign branch_target = pc_in + DATA_W'(4) + (sext_imm << 2);

    logic bubble;
    assign bubble = flush_in || hazard_stall || !id_valid;

    // ID/EX register: reset and bubbles clear it, stall_in holds it, else capture decode.
    always_ff @(posedge clk) begin
        if (rst || (!stall_in && bubble)) begin
            ex_valid     <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_pc        <= '0;
            ex_cmd       <= 4'b0000;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_wb_en     <= 1'b0;
            ex_val1      <= '0;
            ex_val2      <= '0;
            ex_opnd2     <= '0;
            ex_dest      <= 5'd0;
            ex_src1      <= 5'd0;
            ex_src2      <= 5'd0;
        end else if (!stall_in) begin
            ex_valid     <= 1'b1;
            ex_illegal   <= d_ill;
            ex_pc        <= pc_in;
            ex_cmd       <= d_cmd;
            ex_mem_read  <= d_mr;
            ex_mem_write <= d_mw;
            ex_wb_en     <= d_wb;
            ex_val1      <= rs_val;
            ex_val2      <= rt_val;
            ex_opnd2     <= d_opnd2;
            ex_dest      <= d_dest;
            ex_src1      <= rs;
            ex_src2      <= rt;
        end
    end

endmodule
